mem_arbiter: RTL and testbench

- Single-port arbiter between the IF stage (instruction fetch) and the MEM stage (load/store) for the byte-wide unified RAM bus.
- Serialises multi-byte accesses byte by byte.
- Drives the per-stage stall requests (stall_if, stall_mem) consumed by the pipeline stall controller, asserting each until the stage's access completes.

---
 rtl/mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Single-port arbiter between instruction fetch (IF) and load/store (MEM)
//   for a byte-wide unified RAM with one cycle of read latency. Multi-byte
//   accesses are serialised byte by byte, little-endian. MEM wins ties in
//   IDLE. A started transaction always runs to completion.
//
// Ports
//   clk, rst               clock (rising edge), synchronous active-high reset
//   if_req/if_addr         fetch request (word, held until if_done)
//   if_data/if_done        fetched word and one-cycle completion pulse
//   mem_req/mem_we/mem_len load/store request, 1=store, len 00=1B 01=2B 1x=4B
//   mem_addr/mem_wdata     byte address and store data (low n bytes used)
//   mem_rdata/mem_done     zero-extended load data and completion pulse
//   ram_a/ram_dout/ram_wr  registered RAM address, write byte, write enable
//   ram_din                RAM read byte, valid one cycle after its address
//   stall_if/stall_mem     combinational stall requests to the pipeline
//
// Build option
//   FETCH_BUFFER_EN        adds a one-entry fetch buffer; a hit completes
//                          the fetch one cycle after acceptance without any
//                          RAM traffic. Stores overlapping the entry kill it.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int BUF_ADDR_W = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;         // cycles spent in the current access
    logic [2:0]        n_q, n_d;             // access length in bytes: 1, 2 or 4
    logic [ADDR_W-1:0] addr_q, addr_d;       // address of the next byte to drive
    logic [31:0]       wdata_q, wdata_d;     // store data, shifted down one byte per write
    logic [31:0]       asm_q, asm_d;         // read assembly buffer
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic [31:0]       asm_next;             // assembly buffer with this cycle's ram_din merged
    logic              fb_hit;
    logic [31:0]       fb_word;

`ifdef FETCH_BUFFER_EN
    logic                  fb_valid_q, fb_valid_d;
    logic [BUF_ADDR_W-1:0] fb_tag_q, fb_tag_d;
    logic [31:0]           fb_data_q, fb_data_d;

    assign fb_hit  = fb_valid_q && (fb_tag_q == if_addr[ADDR_W-1 -: BUF_ADDR_W]);
    assign fb_word = fb_data_q;
`else
    assign fb_hit  = 1'b0;
    assign fb_word = 32'h0;
`endif

    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // NOTE: every variable gets its hold/idle value first so no path through
    // the case statements leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        ram_wr_d    = 1'b0;
`ifdef FETCH_BUFFER_EN
        fb_valid_d  = fb_valid_q;
        fb_tag_d    = fb_tag_q;
        fb_data_d   = fb_data_q;
        // A byte being written this cycle that falls inside the buffered word
        // makes the entry stale.
        if (ram_wr_q && (ram_a_q[ADDR_W-1 -: BUF_ADDR_W] == fb_tag_q))
            fb_valid_d = 1'b0;
`endif

        // In cycle cnt (cnt >= 1) ram_din carries byte cnt-1.
        asm_next = asm_q;
        case (cnt_q)
            3'd1:    asm_next[7:0]   = ram_din;
            3'd2:    asm_next[15:8]  = ram_din;
            3'd3:    asm_next[23:16] = ram_din;
            3'd4:    asm_next[31:24] = ram_din;
            default: ;
        endcase

        case (state_q)
            IDLE: begin
                // The requester still holds req during its done cycle, so no
                // acceptance happens while a done pulse is out.
                if (!(if_done_q || mem_done_q)) begin
                    if (mem_req) begin
                        state_d  = mem_we ? MEM_WR : MEM_RD;
                        n_d      = len_to_n(mem_len);
                        cnt_d    = 3'd0;
                        asm_d    = 32'h0;
                        ram_a_d  = mem_addr;
                        addr_d   = mem_addr + ADDR_W'(1);
                        ram_wr_d = mem_we;
                        wdata_d  = {8'h00, mem_wdata[31:8]};
                        if (mem_we)
                            ram_dout_d = mem_wdata[7:0];
                    end else if (if_req) begin
                        if (fb_hit) begin
                            if_done_d = 1'b1;
                            if_data_d = fb_word;
                        end else begin
                            state_d = IF_RD;
                            n_d     = 3'd4;
                            cnt_d   = 3'd0;
                            asm_d   = 32'h0;
                            ram_a_d = if_addr;
                            addr_d  = if_addr + ADDR_W'(1);
`ifdef FETCH_BUFFER_EN
                            // Tag is taken now; the entry only becomes valid
                            // again when this fetch completes.
                            fb_tag_d   = if_addr[ADDR_W-1 -: BUF_ADDR_W];
                            fb_valid_d = 1'b0;
`endif
                        end
                    end
                end
            end

            IF_RD, MEM_RD: begin
                if (cnt_q == n_q) begin
                    state_d = IDLE;
                    if (state_q == IF_RD) begin
                        if_done_d = 1'b1;
                        if_data_d = asm_next;
`ifdef FETCH_BUFFER_EN
                        fb_valid_d = 1'b1;
                        fb_data_d  = asm_next;
`endif
                    end else begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = asm_next;
                    end
                end else begin
                    asm_d = asm_next;
                    cnt_d = cnt_q + 3'd1;
                    // Addresses run one cycle ahead of the returning data.
                    if (cnt_q + 3'd1 < n_q) begin
                        ram_a_d = addr_q;
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end
            end

            MEM_WR: begin
                if (cnt_q + 3'd1 < n_q) begin
                    ram_wr_d   = 1'b1;
                    ram_a_d    = addr_q;
                    addr_d     = addr_q + ADDR_W'(1);
                    ram_dout_d = wdata_q[7:0];
                    wdata_d    = {8'h00, wdata_q[31:8]};
                    cnt_d      = cnt_q + 3'd1;
                end else begin
                    state_d    = IDLE;
                    mem_done_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every flop sample the pre-edge
    // values, so the order of statements in this block does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            n_q         <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            asm_q       <= 32'h0;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            ram_a_q     <= '0;
            ram_dout_q  <= 8'h00;
            ram_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
        end
    end

`ifdef FETCH_BUFFER_EN
    always_ff @(posedge clk) begin
        if (rst) fb_valid_q <= 1'b0;
        else     fb_valid_q <= fb_valid_d;
    end

    // NOTE: tag and data storage carry no reset; the valid bit alone decides
    // whether their contents are ever used.
    always_ff @(posedge clk) begin
        fb_tag_q  <= fb_tag_d;
        fb_data_q <= fb_data_d;
    end
`endif

    assign if_data   = if_data_q;
    assign if_done   = if_done_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;
    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = ram_wr_q;
    assign stall_if  = ~rst & if_req  & ~if_done_q;
    assign stall_mem = ~rst & mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed plus randomized bench for mem_arbiter. A byte RAM with one
//   cycle of read latency sits on the RAM port. Expectations come from a
//   reference byte memory updated by the bench's own view of each store, a
//   per-transaction cycle schedule derived from the access rules, and (when
//   FETCH_BUFFER_EN is defined) a one-entry fetch buffer model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [7:0]  ram_din = 8'h00;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        stall_if;
    logic        stall_mem;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ram     [bit [31:0]];   // contents seen by the DUT
    logic [7:0]  ref_mem [bit [31:0]];   // contents the bench expects
    logic [31:0] last_a;                 // expected idle value of ram_a
    bit          fb_valid;
    logic [29:0] fb_tag;
    logic [31:0] fb_data;

    mem_arbiter #(.ADDR_W(32), .BUF_ADDR_W(30)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_data   (if_data),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_len   (mem_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_a     (ram_a),
        .ram_wr    (ram_wr),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    // Synchronous RAM: the byte addressed in one cycle appears the next.
    always @(posedge clk) begin
        if (ram.exists(ram_a)) ram_din <= ram[ram_a];
        else                   ram_din <= init_byte(ram_a);
        if (ram_wr) ram[ram_a] = ram_dout;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a]     = b;
        ref_mem[a] = b;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_if_data"},   if_data,   32'h0);
        check({tag, "_mem_rdata"}, mem_rdata, 32'h0);
        check({tag, "_if_done"},   if_done,   32'h0);
        check({tag, "_mem_done"},  mem_done,  32'h0);
        check({tag, "_ram_a"},     ram_a,     32'h0);
        check({tag, "_ram_dout"},  ram_dout,  32'h0);
        check({tag, "_ram_wr"},    ram_wr,    32'h0);
    endtask

    // One transaction from an idle arbiter. Cycle T is the cycle the request
    // is first presented; outputs are sampled shortly after each falling edge.
    task automatic run_txn(input bit is_mem, input bit we, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit drop, output logic [31:0] got);
        int          n;
        int          done_at;
        bit          hit;
        bit          wr;
        bit          req_lvl;
        logic [31:0] exp_data;
        logic [31:0] a;
        n = 4;
        if (is_mem) n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        wr  = is_mem && we;
        hit = 1'b0;
`ifdef FETCH_BUFFER_EN
        hit = !is_mem && fb_valid && (fb_tag == addr[31:2]);
`endif
        done_at  = hit ? 1 : (wr ? n + 1 : n + 2);
        exp_data = 32'h0;
        if (hit) exp_data = fb_data;
        else if (!wr) begin
            for (int k = 0; k < n; k++) begin
                a = addr + 32'(k);
                exp_data[8*k +: 8] = ref_rd(a);
            end
        end
        got = 32'h0;

        @(posedge clk);
        @(negedge clk);
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        req_lvl = 1'b1;
        #1;
        check("stall_at_accept", is_mem ? stall_mem : stall_if, 32'h1);

        for (int j = 1; j <= done_at; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (drop && j == 2) begin
                if_req = 1'b0; mem_req = 1'b0; req_lvl = 1'b0;
            end
            #1;
            check("done", is_mem ? mem_done : if_done, 32'(j == done_at));
            check("other_done", is_mem ? if_done : mem_done, 32'h0);
            check("stall", is_mem ? stall_mem : stall_if, 32'(req_lvl && j != done_at));
            check("ram_wr", ram_wr, 32'(wr && j <= n));
            a = hit ? last_a : addr + 32'((j - 1 < n - 1) ? j - 1 : n - 1);
            check("ram_a", ram_a, a);
            if (wr && j <= n) check("ram_dout", ram_dout, 32'(wdata[8*(j-1) +: 8]));
            if (j == done_at && !wr) begin
                got = is_mem ? mem_rdata : if_data;
                check("rdata", got, exp_data);
            end
        end
        if_req  = 1'b0;
        mem_req = 1'b0;

        if (!hit) last_a = addr + 32'(n - 1);
        if (wr) begin
            for (int k = 0; k < n; k++) begin
                a = addr + 32'(k);
                ref_mem[a] = wdata[8*k +: 8];
                if (a[31:2] == fb_tag) fb_valid = 1'b0;
            end
        end
        if (!is_mem && !hit) begin
            fb_valid = 1'b1;
            fb_tag   = addr[31:2];
            fb_data  = exp_data;
        end
    endtask

    // Word load and fetch presented in the same idle cycle.
    task automatic run_contention(input logic [31:0] ma, input logic [31:0] ia);
        bit          hit;
        int          if_at;
        logic [31:0] exp_m;
        logic [31:0] exp_i;
        logic [31:0] a;
        hit = 1'b0;
`ifdef FETCH_BUFFER_EN
        hit = fb_valid && (fb_tag == ia[31:2]);
`endif
        for (int k = 0; k < 4; k++) begin
            a = ma + 32'(k); exp_m[8*k +: 8] = ref_rd(a);
            a = ia + 32'(k); exp_i[8*k +: 8] = ref_rd(a);
        end
        if (hit) exp_i = fb_data;
        if_at = hit ? 8 : 13;

        @(posedge clk);
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = ma;
        if_req  = 1'b1; if_addr = ia;
        #1;
        check("cont_stall_if_t0", stall_if, 32'h1);
        check("cont_stall_mem_t0", stall_mem, 32'h1);
        for (int j = 1; j <= if_at; j++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("cont_mem_done", mem_done, 32'(j == 6));
            check("cont_if_done", if_done, 32'(j == if_at));
            check("cont_stall_mem", stall_mem, 32'(j < 6));
            check("cont_stall_if", stall_if, 32'(j < if_at));
            check("cont_ram_wr", ram_wr, 32'h0);
            if (j <= 7 || hit) a = ma + 32'((j - 1 < 3) ? j - 1 : 3);
            else               a = ia + 32'((j - 8 < 3) ? j - 8 : 3);
            check("cont_ram_a", ram_a, a);
            if (j == 6) begin
                check("cont_mem_rdata", mem_rdata, exp_m);
                mem_req = 1'b0;
            end
            if (j == if_at) begin
                check("cont_if_data", if_data, exp_i);
                if_req = 1'b0;
            end
        end
        last_a = hit ? ma + 32'd3 : ia + 32'd3;
        if (!hit) begin
            fb_valid = 1'b1; fb_tag = ia[31:2]; fb_data = exp_i;
        end
    endtask

    // Word load abandoned by a reset during its fourth cycle.
    task automatic run_reset_mid(input logic [31:0] addr);
        @(posedge clk);
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = addr;
        for (int j = 1; j <= 3; j++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("rst_mid_no_done_before", mem_done, 32'h0);
        end
        rst = 1'b1;
        #1;
        check("rst_mid_stall_forced", stall_mem, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; mem_req = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("rst_mid_no_done_after", mem_done, 32'h0);
            check("rst_mid_quiet_wr", ram_wr, 32'h0);
        end
        last_a   = 32'h0;
        fb_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; mem_req = 1'b0; mem_we = 1'b0;
        mem_len = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
        last_a = 32'h0; fb_valid = 1'b0; fb_tag = 30'h0; fb_data = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        if_req = 1'b1; mem_req = 1'b1;
        #1;
        check("reset_stall_if", stall_if, 32'h0);
        check("reset_stall_mem", stall_mem, 32'h0);
        if_req = 1'b0; mem_req = 1'b0;
        check_idle_outputs("reset");
        rst = 1'b0;

        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'hA0); preload(32'h103, 8'h00);
        preload(32'h30, 8'h34);  preload(32'h31, 8'hF2);

        // Word fetch, then the same fetch again (buffer hit when enabled).
        run_txn(1'b0, 1'b0, 2'b00, 32'h100, 32'h0, 1'b0, got);
        check("tp_fetch_word", got, 32'h00A00513);
        run_txn(1'b0, 1'b0, 2'b00, 32'h100, 32'h0, 1'b0, got);
        check("tp_fetch_again", got, 32'h00A00513);

        // Byte stores; the one to 0x102 must be seen by the next fetch.
        run_txn(1'b1, 1'b1, 2'b00, 32'h2004, 32'hDEADBEEF, 1'b0, got);
        check("tp_store_ram", ram[32'h2004], 32'hEF);
        run_txn(1'b1, 1'b1, 2'b00, 32'h102, 32'h00000077, 1'b0, got);
        run_txn(1'b0, 1'b0, 2'b00, 32'h100, 32'h0, 1'b0, got);
        check("tp_fetch_after_store", got, 32'h00770513);

        // Half load, zero-extended.
        run_txn(1'b1, 1'b0, 2'b01, 32'h30, 32'h0, 1'b0, got);
        check("tp_half_load", got, 32'h0000F234);

        run_contention(32'h40, 32'h200);

        run_reset_mid(32'h50);
        run_txn(1'b1, 1'b0, 2'b10, 32'h50, 32'h0, 1'b0, got);

        // Address wrap at the top of the address space, and mem_len=11.
        run_txn(1'b1, 1'b1, 2'b10, 32'hFFFFFFFE, 32'hCAFEF00D, 1'b0, got);
        check("wrap_ram_0", ram[32'h0], 32'hFE);
        run_txn(1'b1, 1'b0, 2'b11, 32'hFFFFFFFE, 32'h0, 1'b0, got);
        check("wrap_load", got, 32'hCAFEF00D);

        // Request dropped mid-transaction still completes.
        run_txn(1'b1, 1'b0, 2'b10, 32'h60, 32'h0, 1'b1, got);

        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic [31:0] addr;
            logic [1:0]  len;
            bit          drop;
            kind = $urandom_range(0, 2);
            addr = (($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 : 32'h1000) + 32'($urandom_range(0, 15));
            len  = 2'($urandom_range(0, 3));
            drop = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            case (kind)
                0:       run_txn(1'b0, 1'b0, 2'b00, addr & 32'hFFFFFFFC, 32'h0, drop, got);
                1:       run_txn(1'b1, 1'b0, len, addr, 32'h0, drop, got);
                default: run_txn(1'b1, 1'b1, len, addr, $urandom, drop, got);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
